// File: rtl/fir_pkg.sv
// Constants shared by the FIR filter and its output conditioning stage, plus
// the reference rounding/saturation rule used by later stages.
package fir_pkg;

  localparam int FIR_IN_WIDTH   = 32;
  localparam int FIR_OUT_WIDTH  = 16;
  localparam int FIR_COEF_SHIFT = 15;
  localparam int FIR_EXT_WIDTH  = FIR_IN_WIDTH + 1;

  typedef struct packed {
    logic signed [FIR_OUT_WIDTH-1:0] value;
    logic                            sat;
  } round_sat_t;

  // Round half-up by adding half an LSB before the arithmetic shift, then
  // clamp to the output range. The extra top bit keeps the rounding add from
  // wrapping at the positive extreme.
  function automatic round_sat_t round_sat(input logic [FIR_IN_WIDTH-1:0] x);
    logic signed [FIR_EXT_WIDTH-1:0] ext;
    logic signed [FIR_EXT_WIDTH-1:0] hi;
    logic signed [FIR_EXT_WIDTH-1:0] lo;
    round_sat_t r;
    hi  = (FIR_EXT_WIDTH'(1) << (FIR_OUT_WIDTH-1)) - FIR_EXT_WIDTH'(1);
    lo  = -(FIR_EXT_WIDTH'(1) << (FIR_OUT_WIDTH-1));
    ext = $signed({x[FIR_IN_WIDTH-1], x}) + (FIR_EXT_WIDTH'(1) << (FIR_COEF_SHIFT-1));
    ext = ext >>> FIR_COEF_SHIFT;
    if (ext > hi) begin
      r.value = hi[FIR_OUT_WIDTH-1:0];
      r.sat   = 1'b1;
    end else if (ext < lo) begin
      r.value = lo[FIR_OUT_WIDTH-1:0];
      r.sat   = 1'b1;
    end else begin
      r.value = ext[FIR_OUT_WIDTH-1:0];
      r.sat   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. rdata is the head entry; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];

  // Next-state for storage, pointers and occupancy; clear overrides everything.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fir_out_decim.sv
// FIR output conditioning: keep one sample in DECIM, round half-up from Q15,
// saturate to OUT_WIDTH and queue the result for a valid/ready consumer.
module fir_out_decim
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = FIR_IN_WIDTH,
  parameter int OUT_WIDTH  = FIR_OUT_WIDTH,
  parameter int SHIFT      = FIR_COEF_SHIFT,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 clear,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat_flag,
  output logic                 drop_flag
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int EW = IN_WIDTH + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0]        PHASE_LAST = PW'(DECIM - 1);
  localparam logic signed [EW-1:0] RND  = EW'(1) << (SHIFT - 1);
  localparam logic signed [EW-1:0] OMAX = (EW'(1) << (OUT_WIDTH - 1)) - EW'(1);
  localparam logic signed [EW-1:0] OMIN = -(EW'(1) << (OUT_WIDTH - 1));

  logic [PW-1:0]        phase_q, phase_d;
  logic                 v1_q, v1_d;
  logic signed [EW-1:0] scaled_q, scaled_d;
  logic                 sat_q, sat_d;
  logic                 drop_q, drop_d;
  logic                 keep, pop, clamp_hi, clamp_lo;
  logic                 fifo_full, fifo_empty;
  logic [OUT_WIDTH-1:0] wr_data, head_data;
  logic [AW:0]          fifo_count;

  // Decimation, stage-1 rounding, stage-2 clamp and sticky flag updates.
  always_comb begin
    keep     = in_valid && (phase_q == '0);
    phase_d  = phase_q;
    if (in_valid) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    end
    scaled_d = scaled_q;
    if (keep) begin
      scaled_d = ($signed({in_data[IN_WIDTH-1], in_data}) + RND) >>> SHIFT;
    end
    v1_d     = keep;
    clamp_hi = (scaled_q > OMAX);
    clamp_lo = (scaled_q < OMIN);
    if (clamp_hi) begin
      wr_data = OMAX[OUT_WIDTH-1:0];
    end else if (clamp_lo) begin
      wr_data = OMIN[OUT_WIDTH-1:0];
    end else begin
      wr_data = scaled_q[OUT_WIDTH-1:0];
    end
    pop    = out_valid && out_ready;
    sat_d  = sat_q | (v1_q & (clamp_hi | clamp_lo));
    drop_d = drop_q | (v1_q & fifo_full & ~pop);
    if (clear) begin
      phase_d = '0;
      v1_d    = 1'b0;
      sat_d   = 1'b0;
      drop_d  = 1'b0;
    end
  end

  // Pipeline and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= '0;
      v1_q     <= 1'b0;
      scaled_q <= '0;
      sat_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      v1_q     <= v1_d;
      scaled_q <= scaled_d;
      sat_q    <= sat_d;
      drop_q   <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (v1_q && !clear),
    .pop   (pop && !clear),
    .wdata (wr_data),
    .rdata (head_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head data is forced to zero whenever nothing is queued.
  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_empty ? '0 : head_data;
  assign sat_flag  = sat_q;
  assign drop_flag = drop_q;

endmodule

// File: tb/tb_fir_out_decim.sv
// Scoreboard bench for fir_out_decim: the driver feeds a high-level model that
// queues expected outputs; an independent monitor pops and compares them.
module tb_fir_out_decim;

  localparam int DECIM = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_valid, sat_flag, drop_flag;

  fir_out_decim #(
    .IN_WIDTH(32), .OUT_WIDTH(16), .SHIFT(15), .DECIM(DECIM), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sat_flag(sat_flag), .drop_flag(drop_flag)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad = 0;
  int     exp_q[$];
  bit     pend_v = 0;
  int     pend_val = 0;
  bit     pend_sat = 0;
  longint nvalid = 0;
  bit     exp_sat = 0;
  bit     exp_drop = 0;

  // Round half-up of x / 2^15, then clamp to the signed 16-bit range.
  function automatic int ref_scale(input logic [31:0] x, output bit sat);
    longint v;
    v = longint'($signed(x)) + 64'sd16384;
    v = v >>> 15;
    sat = 1'b0;
    if (v > 32767) begin v = 32767; sat = 1'b1; end
    if (v < -32768) begin v = -32768; sat = 1'b1; end
    return int'(v);
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_v   = 0;
    nvalid   = 0;
    exp_sat  = 0;
    exp_drop = 0;
  endtask

  // One clock: check flags from the previous edge, drive inputs, and advance
  // the model to what the coming edge should do.
  task automatic cycle(input bit iv, input logic [31:0] d, input bit rdy, input bit clr);
    int sz;
    bit pop;
    bit s;
    @(negedge clk);
    check("sat_flag", sat_flag, exp_sat);
    check("drop_flag", drop_flag, exp_drop);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy && !clr;
    clear     = clr;
    if (clr) begin
      model_reset();
    end else begin
      sz  = exp_q.size();
      pop = out_ready && (sz > 0);
      if (pend_v) begin
        if (sz < DEPTH || pop) exp_q.push_back(pend_val);
        else exp_drop = 1;
        if (pend_sat) exp_sat = 1;
      end
      pend_v = 0;
      if (iv) begin
        if (nvalid % DECIM == 0) begin
          pend_val = ref_scale(d, s);
          pend_sat = s;
          pend_v   = 1;
        end
        nvalid++;
      end
    end
  endtask

  task automatic kept(input logic [31:0] d, input bit rdy);
    cycle(1, d, rdy, 0);
    for (int i = 1; i < DECIM; i++) cycle(1, $urandom, rdy, 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, '0, rdy, 0);
  endtask

  // Monitor: compare every handshake against the scoreboard and check that a
  // stalled head does not change.
  bit          prev_stall = 0;
  logic [15:0] prev_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall && out_valid) check("hold_data", out_data, prev_data);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %0d expected none", $signed(out_data));
          end else begin
            check("out_data", longint'($signed(out_data)), longint'(exp_q.pop_front()));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  int round_in[5] = '{16383, 16384, -16384, -16385, 114688};
  bit rc, rv;
  logic [31:0] rd;

  initial begin
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_drop", drop_flag, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Ramp through the decimator, with first-sample latency checks.
    for (int k = 0; k < 16; k++) begin
      cycle(1, 32'(32768 * k), 1, 0);
      if (k == 1) begin #2; check("latency_e0", out_valid, 0); end
      if (k == 2) begin #2; check("latency_e1", out_valid, 1); end
    end
    idle(4, 1);

    // Rounding boundaries.
    for (int i = 0; i < 5; i++) kept(32'(round_in[i]), 1);
    idle(4, 1);

    // Saturation at both extremes, then clear.
    kept(32'h7FFF_FFFF, 1);
    kept(32'h8000_0000, 1);
    idle(4, 1);
    check("sat_high", sat_flag, 1);
    cycle(0, '0, 0, 1);
    idle(2, 1);

    // Full FIFO with simultaneous push and pop: no drop.
    for (int i = 1; i <= DEPTH; i++) kept(32'(32768 * i), 0);
    idle(2, 0);
    cycle(1, 32'(32768 * 100), 0, 0);
    cycle(0, '0, 1, 0);
    idle(3, 0);
    check("pushpop_nodrop", drop_flag, 0);
    idle(DEPTH + 4, 1);
    check("pushpop_empty", out_valid, 0);

    // Overflow: 10 kept samples into an 8-deep FIFO with the consumer stalled.
    cycle(0, '0, 0, 1);
    for (int i = 1; i <= 10; i++) kept(32'(32768 * i), 0);
    idle(3, 0);
    check("ovf_valid", out_valid, 1);
    check("ovf_head", out_data, 1);
    check("ovf_drop", drop_flag, 1);
    idle(DEPTH + 4, 1);
    check("ovf_drained", out_valid, 0);

    // Asynchronous reset with entries queued and a sample in stage 1.
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) kept(32'(32768 * (i + 20)), 0);
    cycle(1, 32'(32768 * 30), 0, 0);
    @(negedge clk);
    in_valid  = 0;
    out_ready = 0;
    #3 reset = 1'b0;
    #1 check("reset_async_valid", out_valid, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(1, 32'(32768 * 7), 1, 0);
    cycle(1, 32'(32768 * 9), 1, 0);
    idle(4, 1);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      rc = ($urandom_range(0, 199) == 0);
      rv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       rd = $urandom;
        1:       rd = 32'($signed(32'($urandom_range(0, 2097151))) - 1048576);
        2:       rd = 32'($signed(32'($urandom_range(0, 65535))) - 32768);
        default: rd = 32'($signed(32'($urandom_range(0, 2147483647))) - 1073741824) <<< 1;
      endcase
      cycle(rv, rd, $urandom_range(0, 1) == 1, rc);
    end

    // Drain with a bounded budget.
    for (int n = 0; n < 40 && (exp_q.size() != 0 || pend_v); n++) cycle(0, '0, 1, 0);
    idle(2, 1);
    check("drain_left", exp_q.size(), 0);
    check("final_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
